// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : RV32I fetch stage - sequential PC generation, imem valid/ready
//             requests, {pc, instr} buffer and redirect/flush handling.
//  Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic [4:0]  op,
    output logic [2:0]  funct3,
    output logic        funct7_6
);

    localparam int unsigned c_PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned c_CNT_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [c_PTR_W-1:0] c_PTR_ONE = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] c_BOOT  = 2'd0;
    localparam logic [1:0] c_RUN   = 2'd1;
    localparam logic [1:0] c_DRAIN = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_rsp_pc;
    logic [c_CNT_W-1:0] r_outstanding;
    logic [c_CNT_W-1:0] w_outstanding_next;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_count_next;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [31:0]        r_fifo_pc    [FIFO_DEPTH];
    logic [31:0]        r_fifo_instr [FIFO_DEPTH];

    logic               w_active;
    logic               w_redirect;
    logic [c_CNT_W:0]   w_inflight;
    logic               w_req_valid;
    logic               w_req_fire;
    logic               w_rsp_take;
    logic               w_push;
    logic               w_drop;
    logic               w_pop;
    logic               w_if_valid;
    logic [31:0]        w_target;
    logic               w_unused_pc_bits;

    // Redirects are ignored during the single BOOT cycle.
    assign w_active    = (r_state != c_BOOT);
    assign w_redirect  = redirect_valid && w_active;
    assign w_target    = {redirect_pc[31:2], 2'b00};
    assign w_unused_pc_bits = &{1'b0, redirect_pc[1:0]};

    // Buffered plus in-flight entries may never exceed the buffer size.
    assign w_inflight  = {1'b0, r_count} + {1'b0, r_outstanding};
    assign w_req_valid = (r_state == c_RUN) && (w_inflight < c_DEPTH) && !redirect_valid;
    assign w_req_fire  = w_req_valid && imem_req_ready;
    assign w_rsp_take  = imem_rsp_valid && w_active;
    assign w_push      = imem_rsp_valid && (r_state == c_RUN) && !w_redirect;
    assign w_drop      = imem_rsp_valid && (r_state == c_DRAIN);

    assign w_if_valid  = (r_count != '0) && !redirect_valid;
    assign w_pop       = w_if_valid && if_ready;

    always_comb begin
        w_outstanding_next = r_outstanding;
        if (w_req_fire) begin
            w_outstanding_next = w_outstanding_next + c_CNT_ONE;
        end
        if (w_rsp_take) begin
            w_outstanding_next = w_outstanding_next - c_CNT_ONE;
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (w_push) begin
            w_count_next = w_count_next + c_CNT_ONE;
        end
        if (w_pop) begin
            w_count_next = w_count_next - c_CNT_ONE;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT: begin
                w_state_next = c_RUN;
            end
            c_RUN, c_DRAIN: begin
                if (w_redirect) begin
                    w_state_next = (w_outstanding_next != '0) ? c_DRAIN : c_RUN;
                end else if (r_state == c_DRAIN) begin
                    if ((r_drop_cnt == '0) || (w_drop && (r_drop_cnt == c_CNT_ONE))) begin
                        w_state_next = c_RUN;
                    end
                end
            end
            default: begin
                w_state_next = c_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= c_BOOT;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_next;
            r_outstanding <= w_outstanding_next;
            if (w_redirect) begin
                r_fetch_pc <= w_target;
                r_rsp_pc   <= w_target;
                r_drop_cnt <= w_outstanding_next;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if (w_drop && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - c_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_redirect) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            r_count <= w_count_next;
        end
    end

    // Storage is reset so the head reads as zero straight out of reset.
    for (genvar i = 0; i < FIFO_DEPTH; i++) begin : g_fifo_entry
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_fifo_pc[i]    <= '0;
                r_fifo_instr[i] <= '0;
            end else if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
                r_fifo_pc[i]    <= r_rsp_pc;
                r_fifo_instr[i] <= imem_rsp_data;
            end
        end
    end

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign if_valid       = w_if_valid;
    assign if_instr       = r_fifo_instr[r_rd_ptr];
    assign if_pc          = r_fifo_pc[r_rd_ptr];
    assign if_pc4         = if_pc + 32'd4;
    assign op             = if_instr[6:2];
    assign funct3         = if_instr[14:12];
    assign funct7_6       = if_instr[30];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Scoreboard bench for instr_fetch with a latency-programmable
//             in-order instruction memory model.
//  Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_instr_fetch;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'd0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        if_valid;
    logic        if_ready = 1'b0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc4;
    logic [4:0]  op;
    logic [2:0]  funct3;
    logic        funct7_6;

    instr_fetch #(
        .RESET_PC   (c_RESET_PC),
        .FIFO_DEPTH (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc4         (if_pc4),
        .op             (op),
        .funct3         (funct3),
        .funct7_6       (funct7_6)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  op;
        logic [2:0]  f3;
        logic        f76;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    exp_t  exp_q[$];
    pend_t pend_q[$];
    int    n_tests = 0;
    int    n_fail = 0;
    int    lat = 1;
    int    mem_cyc = 0;

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (a == 32'h0000_0200) return 32'h40B5_0533;
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_data(pc);
        e.op    = e.instr[6:2];
        e.f3    = e.instr[14:12];
        e.f76   = e.instr[30];
        exp_q.push_back(e);
    endtask

    // Entry for address 0x200 with hand-decoded fields of 0x40B50533.
    task automatic push_decode_exp();
        exp_t e;
        e.pc    = 32'h0000_0200;
        e.instr = 32'h40B5_0533;
        e.op    = 5'b01100;
        e.f3    = 3'b000;
        e.f76   = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        imem_req_ready = 1'b1;
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(input string name);
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        check32(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
        check32({tag, "_req_addr"},  imem_req_addr, c_RESET_PC);
        check32({tag, "_if_valid"},  32'(if_valid), 32'd0);
        check32({tag, "_if_instr"},  if_instr, 32'd0);
        check32({tag, "_if_pc"},     if_pc, 32'd0);
        check32({tag, "_if_pc4"},    if_pc4, 32'd4);
        check32({tag, "_fields"},    32'({op, funct3, funct7_6}), 32'd0);
    endtask

    // Memory model: in-order responses, each at least `lat` cycles after acceptance.
    initial begin
        logic        fire;
        logic        rfire;
        logic [31:0] a;
        pend_t       p;
        forever begin
            @(negedge clk);
            fire  = imem_req_valid && imem_req_ready && rst_n;
            rfire = imem_rsp_valid && rst_n;
            a     = imem_req_addr;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                pend_q.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (rfire && pend_q.size() > 0) void'(pend_q.pop_front());
                if (fire) begin
                    p.addr = a;
                    p.due  = mem_cyc + lat;
                    pend_q.push_back(p);
                end
            end
            mem_cyc++;
            if (rst_n && pend_q.size() > 0 && pend_q[0].due <= mem_cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = mem_data(pend_q[0].addr);
            end else begin
                imem_rsp_valid = 1'b0;
            end
        end
    end

    // Monitor: every decode handshake is checked against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && if_valid && if_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_delivery: got pc 0x%08h, required no delivery", if_pc);
                end else begin
                    e = exp_q.pop_front();
                    check32("if_pc",    if_pc, e.pc);
                    check32("if_pc4",   if_pc4, e.pc + 32'd4);
                    check32("if_instr", if_instr, e.instr);
                    check32("op",       32'(op), 32'(e.op));
                    check32("funct3",   32'(funct3), 32'(e.f3));
                    check32("funct7_6", 32'(funct7_6), 32'(e.f76));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nreq;
        int stale;
        int last_stale;
        int first_req;
        int j;
        logic [31:0] first_addr;

        // Reset values, then startup with 1-cycle memory and decode always ready.
        lat = 1;
        if_ready = 1'b1;
        tick();
        tick();
        check_reset_values("rst");
        for (int i = 0; i < 8; i++) push_exp(c_RESET_PC + 32'(4 * i));
        rst_n = 1'b1;
        @(negedge clk);
        check32("boot_no_req", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            check32("start_req_valid", 32'(imem_req_valid), 32'd1);
            check32("start_req_addr", imem_req_addr, c_RESET_PC + 32'(4 * i));
        end
        wait_empty("start_drain");
        if_ready = 1'b0;

        // Backpressure: exactly four requests, then resume at 0x110 after release.
        do_reset();
        nreq = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                if (nreq < 4) check32("bp_req_addr", imem_req_addr, c_RESET_PC + 32'(4 * nreq));
                nreq++;
            end
            tick();
        end
        check32("bp_req_count", 32'(nreq), 32'd4);
        check32("bp_stalled", 32'(imem_req_valid), 32'd0);
        for (int i = 0; i < 8; i++) push_exp(c_RESET_PC + 32'(4 * i));
        if_ready = 1'b1;
        first_addr = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                first_addr = imem_req_addr;
                break;
            end
            tick();
        end
        check32("bp_resume_addr", first_addr, 32'h0000_0110);
        wait_empty("bp_drain");
        if_ready = 1'b0;

        // Redirect with two outstanding requests on 3-cycle memory.
        lat = 3;
        do_reset();
        nreq = 0;
        j = 0;
        while (nreq < 2 && j < 10) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nreq++;
            tick();
            j++;
        end
        check32("rd_two_accepted", 32'(nreq), 32'd2);
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_q.delete();
        push_decode_exp();
        for (int i = 1; i < 4; i++) push_exp(32'h0000_0200 + 32'(4 * i));
        if_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        stale = 0;
        last_stale = -10;
        first_req = -1;
        first_addr = 32'hFFFF_FFFF;
        j = 0;
        while (first_req < 0 && j < 20) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                first_req = j;
                first_addr = imem_req_addr;
            end else if (imem_rsp_valid) begin
                stale++;
                last_stale = j;
            end
            tick();
            j++;
        end
        check32("rd_stale_count", 32'(stale), 32'd2);
        check32("rd_first_req_cycle", 32'(first_req), 32'(last_stale + 1));
        check32("rd_target_addr", first_addr, 32'h0000_0200);
        wait_empty("rd_drain");
        if_ready = 1'b0;

        // Redirect coinciding with a response and a ready decoder, buffer non-empty.
        lat = 1;
        do_reset();
        j = 0;
        while (!(if_valid && imem_rsp_valid) && j < 12) begin
            tick();
            j++;
        end
        check32("sim_setup", 32'(if_valid && imem_rsp_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0203;
        exp_q.delete();
        push_decode_exp();
        push_exp(32'h0000_0204);
        push_exp(32'h0000_0208);
        if_ready = 1'b1;
        #1;
        check32("sim_redirect_blocks_valid", 32'(if_valid), 32'd0);
        check32("sim_redirect_blocks_req", 32'(imem_req_valid), 32'd0);
        tick();
        redirect_valid = 1'b0;
        #1;
        check32("sim_flushed", 32'(if_valid), 32'd0);
        check32("sim_target_req", 32'(imem_req_valid), 32'd1);
        check32("sim_aligned_addr", imem_req_addr, 32'h0000_0200);
        wait_empty("sim_drain");
        if_ready = 1'b0;

        // Asynchronous reset while draining stale responses.
        lat = 3;
        do_reset();
        nreq = 0;
        j = 0;
        while (nreq < 2 && j < 10) begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) nreq++;
            tick();
            j++;
        end
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        check32("ar_drain_no_req", 32'(imem_req_valid), 32'd0);
        check32("ar_drain_addr", imem_req_addr, 32'h0000_0300);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("ar");
        tick();
        tick();
        lat = 1;
        exp_q.delete();
        push_exp(c_RESET_PC);
        push_exp(c_RESET_PC + 32'd4);
        if_ready = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        check32("ar_boot_no_req", 32'(imem_req_valid), 32'd0);
        tick();
        @(negedge clk);
        check32("ar_restart_req", 32'(imem_req_valid), 32'd1);
        check32("ar_restart_addr", imem_req_addr, c_RESET_PC);
        wait_empty("ar_drain");
        if_ready = 1'b0;

        tick();
        tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
